// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and helpers for the branch resolve unit.
//   branch_funct3_e : RISC-V conditional-branch funct3 encodings
//   bht_cnt_t       : 2-bit saturating direction counter
//   BHT_RESET       : counter value after reset (weakly not-taken)
//   f3_legal()      : true for the six defined branch conditions
//   bht_next()      : saturating counter update
package branch_resolve_unit_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'd0,
        F3_BNE  = 3'd1,
        F3_BLT  = 3'd4,
        F3_BGE  = 3'd5,
        F3_BLTU = 3'd6,
        F3_BGEU = 3'd7
    } branch_funct3_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_RESET = 2'b01;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
        end else begin
            return (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        end
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Combinational branch-condition evaluator.
//   funct3   : branch condition encoding
//   op1, op2 : rs1 / rs2 operand values
//   cond     : 1 when the condition holds; reserved encodings give 0
module branch_cond
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            cond
);

    // Evaluate the selected comparison
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (op1 == op2);
            F3_BNE:  cond = (op1 != op2);
            F3_BLT:  cond = ($signed(op1) <  $signed(op2));
            F3_BGE:  cond = ($signed(op1) >= $signed(op2));
            F3_BLTU: cond = (op1 <  op2);
            F3_BGEU: cond = (op1 >= op2);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution and bimodal direction prediction.
//   if_pc / if_pred_taken      : fetch-side combinational prediction lookup
//   ex_*                       : EX-stage branch/jump being resolved
//   redirect_valid/redirect_pc : registered one-cycle mispredict redirect
//   branch_count               : saturating count of accepted resolves
//   mispredict_count           : saturating count of redirects issued
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_jump,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_op1,
    input  logic [XLEN-1:0]  ex_op2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_cnt_t         bht_r [BHT_ENTRIES];
    logic             redirect_valid_r;
    logic [XLEN-1:0]  redirect_pc_r;
    logic [CNT_W-1:0] branch_count_r;
    logic [CNT_W-1:0] mispredict_count_r;

    logic [IDX_W-1:0] if_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic             cond_s;
    logic             accept_s;
    logic             taken_s;
    logic             mispredict_s;
    logic             table_upd_s;
    logic [XLEN-1:0]  next_pc_s;
    logic             unused_pc_bits_s;

    assign if_idx_s = if_pc[IDX_W+1:2];
    assign ex_idx_s = ex_pc[IDX_W+1:2];
    assign unused_pc_bits_s = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    // No bypass: a same-cycle update to this index is seen next cycle
    assign if_pred_taken = bht_r[if_idx_s][1];

    branch_cond #(.XLEN(XLEN)) u_cond (
        .funct3 (ex_funct3),
        .op1    (ex_op1),
        .op2    (ex_op2),
        .cond   (cond_s)
    );

    // While a redirect is out, the EX instruction is wrong-path and ignored
    assign accept_s     = ex_valid & (ex_is_jump | ex_is_branch) & ~redirect_valid_r;
    assign taken_s      = ex_is_jump | (ex_is_branch & cond_s);
    assign mispredict_s = accept_s &
                          ((taken_s != ex_pred_taken) |
                           (taken_s & ex_pred_taken & (ex_pred_target != ex_target)));
    assign table_upd_s  = accept_s & ~ex_is_jump & ex_is_branch & f3_legal(ex_funct3);
    assign next_pc_s    = taken_s ? ex_target : ex_pc + {{(XLEN-3){1'b0}}, 3'd4};

    // Direction counter table, held in flops for asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= BHT_RESET;
            end
        end else if (table_upd_s) begin
            bht_r[ex_idx_s] <= bht_next(bht_r[ex_idx_s], taken_s);
        end else begin
            bht_r[ex_idx_s] <= bht_r[ex_idx_s];
        end
    end

    // One-cycle redirect pulse; the target holds between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
        end else if (mispredict_s) begin
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= next_pc_s;
        end else begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= redirect_pc_r;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_r     <= {CNT_W{1'b0}};
            mispredict_count_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && (branch_count_r != {CNT_W{1'b1}})) begin
                branch_count_r <= branch_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                branch_count_r <= branch_count_r;
            end
            if (mispredict_s && (mispredict_count_r != {CNT_W{1'b1}})) begin
                mispredict_count_r <= mispredict_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                mispredict_count_r <= mispredict_count_r;
            end
        end
    end

    assign redirect_valid   = redirect_valid_r;
    assign redirect_pc      = redirect_pc_r;
    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed resolves push expected
// redirect targets into a queue, a negedge monitor pops and compares them.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;
    localparam int CNT_W = 32;
    localparam int SAT_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [XLEN-1:0]   if_pc;
    logic              if_pred_taken;
    logic              ex_valid, ex_is_jump, ex_is_branch, ex_pred_taken;
    logic [2:0]        ex_funct3;
    logic [XLEN-1:0]   ex_op1, ex_op2, ex_pc, ex_target, ex_pred_target;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic [CNT_W-1:0]  branch_count, mispredict_count;

    logic              s_pred_taken, s_redirect_valid;
    logic [XLEN-1:0]   s_redirect_pc;
    logic [SAT_W-1:0]  s_branch_count, s_mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_is_branch(ex_is_branch),
        .ex_funct3(ex_funct3), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(64), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(s_pred_taken),
        .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_is_branch(ex_is_branch),
        .ex_funct3(ex_funct3), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .branch_count(s_branch_count),
        .mispredict_count(s_mispredict_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int bc_exp = 0;
    int mc_exp = 0;
    logic [XLEN-1:0] exp_q[$];
    logic prev_rv = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expected target
    always @(negedge clk) begin
        if (rst_n === 1'b1 && redirect_valid === 1'b1) begin
            check("redirect_pulse_len", {63'd0, prev_rv}, 64'd0);
            if (exp_q.size() == 0) begin
                check("redirect_unexpected", 64'd1, 64'd0);
            end else begin
                check("redirect_pc", {32'd0, redirect_pc}, {32'd0, exp_q.pop_front()});
            end
        end
        prev_rv = (rst_n === 1'b1) && (redirect_valid === 1'b1);
    end

    task automatic drive(input logic j, input logic b, input logic [2:0] f3,
                         input logic [31:0] o1, input logic [31:0] o2,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_is_jump = j; ex_is_branch = b; ex_funct3 = f3;
        ex_op1 = o1; ex_op2 = o2; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    // One accepted resolve; a mispredict is followed by an idle cycle
    task automatic res(input logic j, input logic b, input logic [2:0] f3,
                       input logic [31:0] o1, input logic [31:0] o2,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt,
                       input logic exp_rd, input logic [31:0] exp_pc);
        drive(j, b, f3, o1, o2, pc, tgt, pt, ptgt);
        bc_exp++;
        if (exp_rd) begin
            exp_q.push_back(exp_pc);
            mc_exp++;
        end
        idle();
        ex_valid = 1'b0;
        if (exp_rd) idle();
    endtask

    task automatic pred(input string name, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(name, {63'd0, if_pred_taken}, {63'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; if_pc = 32'd0; ex_valid = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        ex_valid = 1'b0;
        #12 rst_n = 1'b1;
        idle();

        // Reset state
        for (int i = 0; i < 64; i++) pred("reset_pred", 32'(i * 4), 1'b0);
        check("reset_rv", {63'd0, redirect_valid}, 64'd0);
        check("reset_rpc", {32'd0, redirect_pc}, 64'd0);
        check("reset_bc", 64'(branch_count), 64'd0);
        check("reset_mc", 64'(mispredict_count), 64'd0);
        idle();

        // BEQ taken, predicted not-taken
        res(1'b0, 1'b1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h180, 1'b0, 32'h0, 1'b1, 32'h180);
        pred("beq_pred", 32'h100, 1'b1);
        // BLT signed taken, correctly predicted; index 1 goes 1->2
        res(1'b0, 1'b1, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h304, 32'h400, 1'b1, 32'h400, 1'b0, 32'h0);
        pred("blt_pred", 32'h304, 1'b1);
        // BLTU not-taken, predicted taken -> pc+4; index 0 goes 2->1
        res(1'b0, 1'b1, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h280, 1'b1, 32'h280, 1'b1, 32'h204);
        pred("bltu_pred", 32'h100, 1'b0);

        // Saturate up at index 5
        for (int i = 0; i < 4; i++)
            res(1'b0, 1'b1, 3'd1, 32'd1, 32'd2, 32'h14, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        pred("sat_up", 32'h14, 1'b1);
        res(1'b0, 1'b1, 3'd5, 32'd1, 32'd2, 32'h14, 32'h40, 1'b1, 32'h40, 1'b1, 32'h18);
        pred("sat_up_nowrap", 32'h14, 1'b1);
        res(1'b0, 1'b1, 3'd5, 32'd1, 32'd2, 32'h14, 32'h40, 1'b1, 32'h40, 1'b1, 32'h18);
        pred("dec_to_1", 32'h14, 1'b0);
        // Saturate down
        for (int i = 0; i < 4; i++)
            res(1'b0, 1'b1, 3'd7, 32'h10, 32'h20, 32'h14, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        res(1'b0, 1'b1, 3'd0, 32'd7, 32'd7, 32'h14, 32'h40, 1'b0, 32'h0, 1'b1, 32'h40);
        pred("sat_dn_nowrap", 32'h14, 1'b0);
        res(1'b0, 1'b1, 3'd0, 32'd7, 32'd7, 32'h14, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        pred("inc_to_2", 32'h14, 1'b1);

        // Reserved funct3: not-taken, table unchanged
        res(1'b0, 1'b1, 3'd2, 32'd9, 32'd9, 32'h14, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        pred("rsv2_pred", 32'h14, 1'b1);
        res(1'b0, 1'b1, 3'd3, 32'd9, 32'd9, 32'h14, 32'h40, 1'b1, 32'h40, 1'b1, 32'h18);
        pred("rsv3_pred", 32'h14, 1'b1);

        // pc+4 wraps at the top of the address space
        res(1'b0, 1'b1, 3'd0, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h40, 1'b1, 32'h40, 1'b1, 32'h0);

        // JAL target mispredict, then a squashed would-be mispredict
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h14, 32'h600, 1'b1, 32'h500);
        exp_q.push_back(32'h600); bc_exp++; mc_exp++;
        idle();
        drive(1'b0, 1'b1, 3'd0, 32'd3, 32'd3, 32'h20, 32'h80, 1'b0, 32'h0);
        idle();
        ex_valid = 1'b0;
        idle();
        pred("squash_tbl", 32'h20, 1'b0);
        pred("jal_tbl", 32'h14, 1'b1);
        check("bc", 64'(branch_count), 64'(bc_exp));
        check("mc", 64'(mispredict_count), 64'(mc_exp));
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // Async reset while a redirect is pending
        drive(1'b0, 1'b1, 3'd0, 32'd1, 32'd1, 32'h100, 32'h140, 1'b0, 32'h0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("pre_rst_rv", {63'd0, redirect_valid}, 64'd1);
        check("pre_rst_rpc", {32'd0, redirect_pc}, 64'h140);
        #1 rst_n = 1'b0;
        #1;
        check("rst_rv", {63'd0, redirect_valid}, 64'd0);
        check("rst_rpc", {32'd0, redirect_pc}, 64'd0);
        check("rst_bc", 64'(branch_count), 64'd0);
        check("rst_mc", 64'(mispredict_count), 64'd0);
        pred("rst_tbl", 32'h14, 1'b0);
        rst_n = 1'b1;
        bc_exp = 0; mc_exp = 0;
        idle();

        // Perf counter saturation on the narrow instance
        for (int i = 0; i < 9; i++)
            res(1'b0, 1'b1, 3'd1, 32'd1, 32'd2, 32'h30, 32'h90, 1'b1, 32'h90, 1'b0, 32'h0);
        check("sat_bc", 64'(s_branch_count), 64'd7);
        check("sat_mc", 64'(s_mispredict_count), 64'd0);
        check("bc_after", 64'(branch_count), 64'(bc_exp));
        idle();
        check("queue_final", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch-resolution and direction-prediction unit for the RISC-V core. Holds a bimodal table of 2-bit saturating counters read by fetch, resolves conditional branches and jumps in EX, and issues a registered, one-cycle redirect on any direction or target mispredict. Also keeps saturating branch and mispredict event counters for performance monitoring.

## Interface
- XLEN, 32, operand / PC width.
- BHT_ENTRIES, 64, counter-table depth; power of two, ≥ 4.
- CNT_W, 32, width of each performance counter.
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_pc  in  XLEN  fetch PC to predict.
- if_pred_taken  out  1  combinational prediction for if_pc, equal to counter[1].
- ex_valid  in  1  instruction in EX is valid.
- ex_is_jump  in  1  JAL/JALR.
- ex_is_branch  in  1  conditional branch.
- ex_funct3  in  3  branch condition.
- ex_op1, ex_op2  in  XLEN  rs1 / rs2 values.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_target  in  XLEN  computed taken target.
- ex_pred_taken  in  1  prediction carried down from fetch.
- ex_pred_target  in  XLEN  target fetch followed when predicting taken.
- redirect_valid  out  1  registered mispredict pulse.
- redirect_pc  out  XLEN  correct next PC.
- branch_count  out  CNT_W  resolved branches and jumps.
- mispredict_count  out  CNT_W  redirects issued.

## Operation
- Index: pc[log2(BHT_ENTRIES)+1:2], applied to both if_pc and ex_pc.
- Conditions: BEQ 0 (==), BNE 1 (!=), BLT 4 (signed <), BGE 5 (signed >=), BLTU 6 (unsigned <), BGEU 7 (unsigned >=). Reserved funct3 values 2 and 3 resolve as not-taken.
- Actual taken = ex_is_jump | (ex_is_branch & cond). ex_is_jump takes priority when both are set.
- A resolve is accepted when ex_valid & (ex_is_jump | ex_is_branch) & !redirect_valid.
- Mispredict on an accepted resolve:
  - (taken != ex_pred_taken), or
  - (taken & ex_pred_taken & ex_pred_target != ex_target).
- Redirect target: ex_target if taken, else ex_pc + 4. Arithmetic is modulo 2^XLEN, so wrap-around at the top of the address space is allowed.
- Counter update, applied only on accepted conditional branches with a legal funct3:
  - taken: increment, saturating at 3;
  - not-taken: decrement, saturating at 0.
  - Jumps and reserved funct3 leave the table unchanged.
- branch_count increments on every accepted resolve. mispredict_count increments on every mispredict. Both saturate at all-ones and do not wrap.
- Squash: while redirect_valid is high, the EX instruction is wrong-path. It is ignored: no table update, no counting, no new redirect.

## Timing
- Reset values:
  - every counter = 2'b01 (weakly not-taken);
  - redirect_valid = 0;
  - redirect_pc = 0;
  - both perf counters = 0.
- Prediction latency is 0 cycles: combinational read of the table.
- Same-cycle read and write of one index: the read returns the pre-update value. There is no bypass.
- Resolve accepted in cycle N → redirect_valid = 1 and redirect_pc valid in cycle N+1. The pulse lasts exactly one cycle.
- redirect_pc holds its last value while redirect_valid = 0.
- Back-to-back mispredicts: the cycle-N+1 resolve is squashed. The next redirect can occur no earlier than N+2.
- Table and counter updates become visible at the clk edge that ends cycle N.
- rst_n asserted mid-operation: all state clears immediately (asynchronous), and any pending redirect is dropped.

## Structure
- RISCV package:
  - branch_funct3_e enum (BEQ…BGEU);
  - bht_cnt_t (logic [1:0]);
  - BHT_RESET constant (2'b01).
- Sub-module branch_cond: combinational compare (XLEN, funct3 → cond). Instantiated once.
- The counter table is a flop array so it resets asynchronously; no RAM inference.

## Test plan
- After reset, for every index: if_pred_taken = 0, counters = 0, redirect_valid = 0.
- BEQ with op1 = op2 = 5 at pc 0x100, pred 0 → cycle N+1: redirect_valid = 1, redirect_pc = ex_target. Index 0 counter goes 1→2, so if_pc = 0x100 predicts taken.
- BLT with op1 = 0xFFFFFFFF, op2 = 1: signed, so taken. BLTU with the same operands: not-taken. With pred 1 and pc 0x200, BLTU redirects to 0x204.
- Four taken branches at one index → counter saturates at 3. Four not-taken branches → saturates at 0. No wrap in either direction.
- JAL with pred taken and pred_target ≠ ex_target → redirect to ex_target, table unchanged. The mispredict on the following cycle is squashed, and mispredict_count increments by exactly 1.
- rst_n dropped while redirect_valid = 1 → redirect_valid = 0 immediately, counters reset. Preloading branch_count to all-ones and resolving once → it stays all-ones.
